// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between four result producers.
// Destination-r0 results are absorbed in the same cycle without using the port.
// Among the remaining requests, one is granted per cycle in round-robin order,
// and the grant is registered into the write-back outputs.
module wb_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [5*NREQ-1:0]     req_dst,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  flush,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       stalled,
    output logic                  wb_we,
    output logic [4:0]            wb_dst,
    output logic [WIDTH-1:0]      wb_data,
    output logic [1:0]            last_grant
);

    // Per-requester views of the flat buses.
    logic [4:0]       w_dst  [NREQ];
    logic [WIDTH-1:0] w_data [NREQ];
    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_r0;

    // Arbitration results.
    logic [1:0]       w_scan_idx;
    logic [1:0]       w_gnt_idx;
    logic             w_gnt_found;
    logic             w_port_grant;
    logic [NREQ-1:0]  w_port_ack;
    logic [4:0]       w_gnt_dst;
    logic [WIDTH-1:0] w_gnt_data;

    // Registered state.
    logic             r_wb_we;
    logic [4:0]       r_wb_dst;
    logic [WIDTH-1:0] r_wb_data;
    logic [1:0]       r_last_grant;

    // Unpack requests and split them into port-eligible and r0-absorbed sets.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_dst[i]  = req_dst[5*i +: 5];
            w_data[i] = req_data[WIDTH*i +: WIDTH];
            w_elig[i] = req[i] && (w_dst[i] != 5'd0);
            w_r0[i]   = req[i] && (w_dst[i] == 5'd0);
        end
    end

    // Round-robin scan starting just after the last port grant; the 2-bit
    // index wraps 3->0 on its own, and the fourth step revisits last_grant.
    always_comb begin
        w_scan_idx  = 2'd0;
        w_gnt_idx   = 2'd0;
        w_gnt_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan_idx = r_last_grant + 2'(k);
            if (!w_gnt_found && w_elig[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    // A port grant only happens outside reset and flush; select its payload.
    always_comb begin
        w_port_grant = w_gnt_found && !reset && !flush;
        w_gnt_dst    = w_dst[w_gnt_idx];
        w_gnt_data   = w_data[w_gnt_idx];
        for (int i = 0; i < NREQ; i++) begin
            w_port_ack[i] = w_port_grant && (w_gnt_idx == 2'(i));
        end
    end

    // Acknowledge and stall outputs: reset silences everything, flush
    // discards all pending requests, otherwise r0 absorption plus the grant.
    always_comb begin
        if (reset) begin
            ack     = '0;
            stalled = '0;
        end else if (flush) begin
            ack     = req;
            stalled = '0;
        end else begin
            ack     = w_r0 | w_port_ack;
            stalled = req & ~ack;
        end
    end

    // Write-back register and round-robin pointer; payload and pointer hold
    // when no port grant occurs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_we      <= 1'b0;
            r_wb_dst     <= 5'd0;
            r_wb_data    <= '0;
            r_last_grant <= 2'd3;
        end else begin
            r_wb_we <= w_port_grant;
            if (w_port_grant) begin
                r_wb_dst     <= w_gnt_dst;
                r_wb_data    <= w_gnt_data;
                r_last_grant <= w_gnt_idx;
            end
        end
    end

    assign wb_we      = r_wb_we;
    assign wb_dst     = r_wb_dst;
    assign wb_data    = r_wb_data;
    assign last_grant = r_last_grant;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the scalar pipeline's single register-file write port between four result producers: the ALU stage, the one-cycle delayed result registers (multiply, shift) and the load path. Each cycle, at most one pending result with a non-zero destination is granted, in round-robin order. The granted result is driven as a registered write-back. Losers receive a stall until they are granted. Results targeting r0 are absorbed without using the port.

## Interface
- WIDTH, 32, data width of each result and of the write port
- NREQ, 4, number of requesters (fixed at 4; index 0..3)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  4  requester i holds a valid result this cycle
- req_dst  input  20  flat {dst3,dst2,dst1,dst0}, 5 bits each, destination register number
- req_data  input  4*WIDTH  flat {d3,d2,d1,d0}, result values
- flush  input  1  squash: discard all current requests this cycle
- ack  output  4  requester i's result is consumed this cycle (combinational)
- stalled  output  4  req[i] & ~ack[i] (combinational)
- wb_we  output  1  register-file write enable (registered)
- wb_dst  output  5  register-file write address (registered)
- wb_data  output  WIDTH  register-file write data (registered)
- last_grant  output  2  index of the most recent port grant (registered)

## Operation
- Requester contract:
  - A requester keeps req, dst and data stable until it sees ack.
  - The requester drops req in the cycle after ack unless it has a new result.
- r0 absorption:
  - A request with dst==0 is acked in the same cycle, whatever the arbitration.
  - It never asserts wb_we and never moves the pointer.
  - Several r0 requests may be acked together.
- Arbitration:
  - Eligible set E = req & (dst!=0).
  - The search starts at (last_grant+1) mod 4 and grants the first eligible index, wrapping 3->0.
  - Exactly one index in E is granted per cycle.
  - The granted index gets ack=1.
  - Every other index in E gets ack=0 and stalled=1.
- Pointer: last_grant is updated to the granted index only when a port grant occurs.
- Write-back register: on a port grant, the next edge loads wb_we=1, wb_dst=granted dst and wb_data=granted data. Otherwise wb_we=0, and wb_dst/wb_data hold their previous values.
- Flush:
  - While flush=1, ack = req (everything pending is discarded) and stalled=0.
  - No port grant occurs, so wb_we=0 next cycle and the pointer holds.
  - A write-back already registered in the flush cycle still completes, because its wb_we was set by the previous edge.
- Reset:
  - While reset=1, ack=0 and stalled=0.
  - reset overrides flush.
  - Any requests pending at reset are dropped by their sources, not by this block.

## Timing
- Grant and ack are combinational from req, req_dst, flush and last_grant, with no added cycle.
- Write latency is 1: a grant in cycle N gives wb_we, wb_dst and wb_data valid during cycle N+1.
- Throughput is one register write per cycle. Under continuous contention from k eligible requesters, each waits at most k-1 cycles.
- Reset values:
  - wb_we=0, wb_dst=0, wb_data=0.
  - last_grant=3, so the first search starts at index 0.
- Boundary cases:
  - A single requester is granted with no stall, whatever the pointer.
  - With all 4 eligible, grants rotate 0,1,2,3,0,...
  - When the pointer wraps from 3, index 0 is checked first.
  - An r0 request and an eligible request in the same cycle are both acked.
- Reset asserted mid-contention:
  - The next cycle has wb_we=0 and last_grant=3.
  - The cycle after reset deasserts is arbitrated from index 0.

## Test plan
- Reset then idle: hold reset 2 cycles, then req=0 -> wb_we=0, wb_dst=0, wb_data=0, last_grant=3, ack=0.
- Single request: req=0010, dst1=7, d1=0xDEADBEEF -> ack=0010, stalled=0 the same cycle; next cycle wb_we=1, wb_dst=7, wb_data=0xDEADBEEF.
- Full contention: req=1111 held, all dst non-zero, each requester dropping its req on ack -> acks in order 0001, 0010, 0100, 1000 over 4 consecutive cycles; stalled counts for requesters 1, 2, 3 are 1, 2, 3 cycles.
- r0 absorption: req=0101, dst0=0, dst2=9 -> ack=0101 in one cycle; next cycle wb_we=1, wb_dst=9; last_grant=2.
- Flush: req=1100, both with non-zero dst, flush=1 -> ack=1100, stalled=0; next cycle wb_we=0; last_grant unchanged.
- Reset mid-operation: with last_grant=1 and req=1111, assert reset for 1 cycle -> wb_we=0 and last_grant=3; first grant after release goes to index 0.
